// File: rtl/pmcc_pkg.sv
// Shared types, widths and decode helpers for the PMC coprocessor sequencer.
package pmcc_pkg;

  localparam int unsigned PMCC_ADDR_W  = 8;
  localparam int unsigned PMCC_INSTR_W = 32;
  localparam int unsigned PMCC_ACT_W   = 24;
  localparam int unsigned PMCC_WAIT_W  = 14;
  localparam int unsigned PMCC_DST_W   = 10;

  typedef enum logic [1:0] {
    PMCC_OP_ACT  = 2'b00,
    PMCC_OP_LOOP = 2'b01,
    PMCC_OP_WAIT = 2'b10,
    PMCC_OP_CTRL = 2'b11
  } pmcc_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_LOAD  = 3'd3,
    ST_EXEC  = 3'd4,
    ST_ACT   = 3'd5,
    ST_WAIT  = 3'd6
  } pmcc_seq_state_t;

  // Instruction length minus one, from the first (opcode) byte.
  function automatic logic [1:0] pmcc_instr_size(input logic [7:0] op_byte);
    case (pmcc_op_t'(op_byte[7:6]))
      PMCC_OP_ACT:  return 2'd3;
      PMCC_OP_LOOP: return 2'd1;
      PMCC_OP_WAIT: return 2'd1;
      default:      return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pmcc_seq_if.sv
// Code-memory, loop-controller and ACT-datapath signals of the sequencer.
interface pmcc_seq_if;
  import pmcc_pkg::*;

  logic                    code_req;
  logic [PMCC_ADDR_W-1:0]  code_addr;
  logic [PMCC_INSTR_W-1:0] code_rdata;
  logic                    pmcc_rst_n;
  logic                    loop;
  logic                    branch;
  logic [PMCC_INSTR_W-1:0] instr;
  logic [1:0]              instr_size;
  logic [PMCC_ADDR_W-1:0]  pc;
  logic                    branch_exec;
  logic [PMCC_DST_W-1:0]   branch_dst;
  logic                    act_valid;
  logic [PMCC_ACT_W-1:0]   act_data;
  logic                    act_ready;

  modport master (
    output code_req, code_addr, pmcc_rst_n, loop, branch, instr, instr_size, pc,
           act_valid, act_data,
    input  code_rdata, branch_exec, branch_dst, act_ready
  );

  modport slave (
    input  code_req, code_addr, pmcc_rst_n, loop, branch, instr, instr_size, pc,
           act_valid, act_data,
    output code_rdata, branch_exec, branch_dst, act_ready
  );

endinterface

// File: rtl/pmcc_sequencer.sv
// PMC coprocessor instruction sequencer: fetch/decode/execute of variable-length
// instructions, loop/branch strobes to the loop controller, WAIT and ACT execution.
module pmcc_sequencer
  import pmcc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PMCC_ADDR_W-1:0] start_pc,
  output logic                   busy,
  output logic                   done,
  pmcc_seq_if.master             bus
);

  pmcc_seq_state_t         state_q, state_d;
  logic [PMCC_ADDR_W-1:0]  pc_q, pc_d;
  logic [PMCC_INSTR_W-1:0] instr_q, instr_d;
  logic [1:0]              size_q, size_d;
  logic [PMCC_WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic                    stop_pend_q, stop_pend_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    code_req_q, code_req_d;
  logic                    pmcc_rst_n_q, pmcc_rst_n_d;
  logic                    loop_q, loop_d;
  logic                    branch_q, branch_d;
  logic                    act_valid_q, act_valid_d;

  pmcc_op_t                op;
  logic                    is_halt;
  logic [PMCC_WAIT_W-1:0]  imm;
  logic [PMCC_ADDR_W-1:0]  pc_exec;
  logic                    unused_dst;

  assign op         = pmcc_op_t'(instr_q[7:6]);
  assign is_halt    = (op == PMCC_OP_CTRL) && instr_q[5];
  assign imm        = {instr_q[5:0], instr_q[15:8]};
  assign pc_exec    = bus.branch_exec ? bus.branch_dst[PMCC_ADDR_W-1:0]
                                      : pc_q + PMCC_ADDR_W'(size_q) + PMCC_ADDR_W'(1);
  // Code space is 256 B, so the upper target bits carry no information.
  assign unused_dst = ^bus.branch_dst[PMCC_DST_W-1:PMCC_ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      size_q       <= '0;
      wait_cnt_q   <= '0;
      stop_pend_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      code_req_q   <= 1'b0;
      pmcc_rst_n_q <= 1'b1;
      loop_q       <= 1'b0;
      branch_q     <= 1'b0;
      act_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      size_q       <= size_d;
      wait_cnt_q   <= wait_cnt_d;
      stop_pend_q  <= stop_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      code_req_q   <= code_req_d;
      pmcc_rst_n_q <= pmcc_rst_n_d;
      loop_q       <= loop_d;
      branch_q     <= branch_d;
      act_valid_q  <= act_valid_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    size_d      = size_q;
    wait_cnt_d  = wait_cnt_q;
    stop_pend_d = stop_pend_q | (stop & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          state_d = ST_INIT;
        end
      end
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: state_d = stop_pend_q ? ST_IDLE : ST_LOAD;
      ST_LOAD: begin
        instr_d = bus.code_rdata;
        size_d  = pmcc_instr_size(bus.code_rdata[7:0]);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_IDLE;
        end else begin
          pc_d    = pc_exec;
          state_d = ST_FETCH;
          if (op == PMCC_OP_ACT) begin
            state_d = ST_ACT;
          end else if ((op == PMCC_OP_WAIT) && (imm != '0)) begin
            state_d    = ST_WAIT;
            wait_cnt_d = imm - PMCC_WAIT_W'(1);
          end
        end
      end
      ST_ACT: begin
        if (bus.act_ready) state_d = ST_FETCH;
      end
      ST_WAIT: begin
        if (stop_pend_q || stop)     state_d = ST_IDLE;
        else if (wait_cnt_q == '0)   state_d = ST_FETCH;
        else                         wait_cnt_d = wait_cnt_q - PMCC_WAIT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) stop_pend_d = 1'b0;

    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    code_req_d   = (state_d == ST_FETCH) && !stop_pend_d;
    pmcc_rst_n_d = (state_d != ST_INIT);
    loop_d       = (state_d == ST_EXEC) && (pmcc_op_t'(instr_d[7:6]) == PMCC_OP_LOOP);
    branch_d     = (state_d == ST_EXEC) && (pmcc_op_t'(instr_d[7:6]) == PMCC_OP_CTRL)
                   && !instr_d[5];
    act_valid_d  = (state_d == ST_ACT);
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.code_req   = code_req_q;
  assign bus.code_addr  = pc_q;
  assign bus.pmcc_rst_n = pmcc_rst_n_q;
  assign bus.loop       = loop_q;
  assign bus.branch     = branch_q;
  assign bus.instr      = instr_q;
  assign bus.instr_size = size_q;
  assign bus.pc         = pc_q;
  assign bus.act_valid  = act_valid_q;
  assign bus.act_data   = instr_q[PMCC_INSTR_W-1:PMCC_INSTR_W-PMCC_ACT_W];

endmodule

// File: tb/tb_pmcc_sequencer.sv
// Self-checking bench for pmcc_sequencer: program-level reference model with
// a code memory, a loop-controller stand-in and a stalling ACT sink.
module tb_pmcc_sequencer;
  import pmcc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop;
  logic [7:0] start_pc;
  logic       busy, done;

  pmcc_seq_if bus ();

  pmcc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .start_pc (start_pc),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 256-byte code memory, one-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk)
    if (bus.code_req)
      bus.code_rdata <= {mem[8'(bus.code_addr + 8'd3)], mem[8'(bus.code_addr + 8'd2)],
                         mem[8'(bus.code_addr + 8'd1)], mem[bus.code_addr]};

  // Loop-controller stand-in: LOOP n makes the following BRANCH jump back n-1 times
  logic [13:0] lc_cnt = '0;
  logic [7:0]  lc_tgt = '0;
  always @(posedge clk) begin
    if (!bus.pmcc_rst_n) lc_cnt <= '0;
    else if (bus.loop) begin
      lc_cnt <= {bus.instr[5:0], bus.instr[15:8]};
      lc_tgt <= bus.pc + 8'd2;
    end else if (bus.branch && lc_cnt > 14'd1) lc_cnt <= lc_cnt - 14'd1;
  end
  always_comb begin
    bus.branch_exec = bus.branch && (lc_cnt > 14'd1);
    bus.branch_dst  = {2'b11, lc_tgt};
  end

  // ACT sink: per-ACT stall counts from stall_q, hold_ready forces back-pressure
  int          stall_q[$];
  int          stall_cur = 0;
  bit          hold_ready = 0;
  logic [23:0] act_q[$];
  logic        prev_valid = 0, prev_ready = 0;
  logic [23:0] prev_data = '0;
  always @(negedge clk) begin
    if (bus.act_valid && prev_valid && !prev_ready)
      chk("act_hold", {8'h0, bus.act_data}, {8'h0, prev_data});
    if (bus.act_valid) begin
      if (!prev_valid) stall_cur = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
      if (hold_ready) bus.act_ready = 1'b0;
      else if (stall_cur > 0) begin
        bus.act_ready = 1'b0;
        stall_cur--;
      end else bus.act_ready = 1'b1;
      if (bus.act_ready) act_q.push_back(bus.act_data);
    end else bus.act_ready = 1'b0;
    prev_valid = bus.act_valid;
    prev_ready = bus.act_ready;
    prev_data  = bus.act_data;
  end

  // Reference model: interprets the program byte by byte
  logic [23:0] exp_q[$];
  int          exp_cyc;
  logic [7:0]  exp_pc;

  task automatic model(input logic [7:0] spc);
    logic [7:0]  p, a1, a2, a3, tgt;
    logic [13:0] cnt, n;
    int          k;
    p = spc; cnt = '0; tgt = '0; k = 0;
    exp_q.delete();
    exp_cyc = 1;
    exp_pc  = spc;
    for (int s = 0; s < 1000; s++) begin
      a1 = p + 8'd1; a2 = p + 8'd2; a3 = p + 8'd3;
      n = {mem[p][5:0], mem[a1]};
      exp_cyc += 3;
      if (mem[p][7:6] == 2'b00) begin
        exp_q.push_back({mem[a3], mem[a2], mem[a1]});
        exp_cyc += 1 + ((k < stall_q.size()) ? stall_q[k] : 0);
        k++;
        p = p + 8'd4;
      end else if (mem[p][7:6] == 2'b01) begin
        cnt = n; tgt = p + 8'd2; p = p + 8'd2;
      end else if (mem[p][7:6] == 2'b10) begin
        exp_cyc += int'(n);
        p = p + 8'd2;
      end else if (mem[p][5]) begin
        exp_pc = p;
        break;
      end else if (cnt > 14'd1) begin
        cnt = cnt - 14'd1; p = tgt;
      end else p = p + 8'd1;
    end
  endtask

  logic [7:0] wa;
  task automatic put(input logic [7:0] b);
    mem[wa] = b;
    wa = wa + 8'd1;
  endtask

  task automatic pulse_start(input logic [7:0] spc, input logic with_stop);
    @(negedge clk);
    start_pc = spc; start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  // Run a program to completion and compare against the model.
  task automatic run_prog(input logic [7:0] spc, input string tag, input logic with_stop);
    int cyc;
    bit got;
    model(spc);
    act_q.delete();
    pulse_start(spc, with_stop);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0; got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (busy) cyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_pc"}, 32'(bus.pc), 32'(exp_pc));
    chk({tag, "_nacts"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({tag, "_act"}, 32'(act_q[i]), 32'(exp_q[i]));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_code_req"}, 32'(bus.code_req), 32'd0);
    chk({tag, "_pmcc_rst_n"}, 32'(bus.pmcc_rst_n), 32'd1);
    chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'd0);
    chk({tag, "_act_valid"}, 32'(bus.act_valid), 32'd0);
    chk({tag, "_act_data"}, 32'(bus.act_data), 32'd0);
    chk({tag, "_loop_branch"}, 32'({bus.loop, bus.branch}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  got, early;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; start_pc = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ACT 0xABCDEF; HALT at 0x10
    wa = 8'h10; put(8'h00); put(8'hEF); put(8'hCD); put(8'hAB); put(8'hE0);
    run_prog(8'h10, "act_halt", 1'b0);

    // ACT with four stalled cycles
    wa = 8'h60; put(8'h00); put(8'h21); put(8'h43); put(8'h65); put(8'hE0);
    stall_q.delete(); stall_q.push_back(4);
    run_prog(8'h60, "act_stall", 1'b0);

    // WAIT 5, WAIT 0, HALT
    wa = 8'h70; put(8'h80); put(8'h05); put(8'h80); put(8'h00); put(8'hE0);
    run_prog(8'h70, "wait", 1'b0);

    // LOOP 3 { ACT } BRANCH; HALT
    wa = 8'h40; put(8'h40); put(8'h03); put(8'h00); put(8'h11); put(8'h22); put(8'h33);
    put(8'hC0); put(8'hE0);
    run_prog(8'h40, "loop3", 1'b0);

    // ACT at 0xFE wraps the pc past 0xFF
    wa = 8'hFE; put(8'h00); put(8'h01); put(8'h02); put(8'h03); put(8'hE0);
    run_prog(8'hFE, "wrap", 1'b0);

    // start and stop together in IDLE: the program still runs
    run_prog(8'h10, "start_stop", 1'b1);

    // stop during WAIT 100
    wa = 8'h20; put(8'h80); put(8'h64); put(8'hE0);
    act_q.delete();
    pulse_start(8'h20, 1'b0);
    repeat (6) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_stop_latency", 32'(n <= 2), 32'd1);
    chk("wait_stop_busy", 32'(busy), 32'd0);
    @(negedge clk);

    // stop during a stalled ACT: abort only after the handshake
    wa = 8'h30; put(8'h00); put(8'h56); put(8'h34); put(8'h12);
    put(8'h00); put(8'h77); put(8'h77); put(8'h77); put(8'hE0);
    stall_q.delete(); act_q.delete(); hold_ready = 1;
    pulse_start(8'h30, 1'b0);
    repeat (5) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    early = 0;
    repeat (4) begin
      if (done) early = 1;
      @(negedge clk);
    end
    chk("act_stop_early_done", 32'(early), 32'd0);
    chk("act_stop_busy", 32'(busy), 32'd1);
    hold_ready = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    chk("act_stop_done", 32'(got), 32'd1);
    chk("act_stop_nacts", 32'(act_q.size()), 32'd1);
    if (act_q.size() > 0) chk("act_stop_data", 32'(act_q[0]), 32'h123456);
    @(negedge clk);

    // asynchronous reset in the middle of an ACT
    wa = 8'h50; put(8'h00); put(8'h5A); put(8'h5A); put(8'h5A); put(8'hE0);
    stall_q.delete(); hold_ready = 1;
    pulse_start(8'h50, 1'b0);
    repeat (4) @(negedge clk);
    chk("rst_pre_valid", 32'(bus.act_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_mid_act");
    @(negedge clk);
    rst_n = 1'b1; hold_ready = 0;
    @(negedge clk);
    run_prog(8'h10, "after_rst", 1'b0);

    // random straight-line programs of ACT / WAIT / BRANCH ending in HALT
    for (int t = 0; t < 12; t++) begin
      logic [7:0] spc;
      int         len;
      spc = 8'($urandom_range(0, 255));
      len = $urandom_range(2, 7);
      wa  = spc;
      stall_q.delete();
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: begin
            put({2'b00, 6'($urandom)}); put(8'($urandom)); put(8'($urandom)); put(8'($urandom));
            stall_q.push_back($urandom_range(0, 3));
          end
          1: begin
            put(8'h80); put(8'($urandom_range(0, 6)));
          end
          default: put({3'b110, 5'($urandom)});
        endcase
      end
      put({3'b111, 5'($urandom)});
      run_prog(spc, $sformatf("rand%0d", t), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
